// File: rtl/seven_seg_sniffer.sv
// -----------------------------------------------------------------------------
// seven_seg_sniffer
//
// Passive receiver for a multiplexed hex seven-segment display bus. Samples the
// segment lines and the digit anodes of a target board and rebuilds the hex
// value being shown, one digit per multiplex dwell. Short dwells and ghosting
// during anode changeover are rejected: a digit is captured only after the bus
// has held still for STABLE_CYCLES consecutive samples with exactly one anode
// selected. Segment patterns outside the hex table are flagged.
//
// Parameters
//   DIGITS         number of multiplexed digits / anode lines (1..8)
//   STABLE_CYCLES  identical consecutive samples needed before capture (>= 2)
//   SEG_ACTIVE_LOW 1: seg_in low = segment lit, 0: high = lit
//   AN_ACTIVE_LOW  1: an_in low = digit selected, 0: high = selected
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   seg_in       in   [7:0] segment lines, bit7 = dp, bits 6:0 = g..a
//   an_in        in   [DIGITS-1:0] anode lines, bit0 = rightmost digit
//   value_out    out  [4*DIGITS-1:0] decoded nibbles, [3:0] = digit0
//   dp_out       out  [DIGITS-1:0] decimal point state per digit
//   digit_valid  out  [DIGITS-1:0] digit holds a legal hex pattern from its latest capture
//   bad_pattern  out  1-cycle pulse: captured pattern neither hex nor blank
//   frame_done   out  1-cycle pulse: every digit captured since the previous pulse
//
// Timing: from a pin change, 2 clocks of synchronizer, STABLE_CYCLES identical
// samples, and the outputs update on the following edge.
// -----------------------------------------------------------------------------
module seven_seg_sniffer #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  bad_pattern,
    output logic                  frame_done
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

    // Counter saturates at CNT_MAX. Reaching CNT_ARM with the sample unchanged
    // means STABLE_CYCLES identical samples have been seen, so the following
    // cycle (CAPTURE) commits them.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic is_one_hot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Returns {legal, nibble}; active-high segment bits 6:0 = g..a.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h67:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [7:0]          seg_s1_q, seg_s2_q;
    logic [DIGITS-1:0]   an_s1_q, an_s2_q;
    logic [7:0]          prev_seg_q, prev_seg_d;
    logic [DIGITS-1:0]   prev_an_q, prev_an_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                bad_q, bad_d;
    logic                frame_q, frame_d;

    // Normalised (active-high) sample and change detect
    logic [7:0]          seg_smp;
    logic [DIGITS-1:0]   an_smp;
    logic                changed;
    logic                smp_one_hot;
    logic                capture;

    assign seg_smp     = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    assign an_smp      = AN_ACTIVE_LOW  ? ~an_s2_q  : an_s2_q;
    assign changed     = (seg_smp != prev_seg_q) || (an_smp != prev_an_q);
    assign smp_one_hot = is_one_hot(an_smp);

    assign prev_seg_d = seg_smp;
    assign prev_an_d  = an_smp;

    // Stability counter: restarts on any change, otherwise counts up and sticks.
    always_comb begin
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                // Leaving IDLE always coincides with a sample change, so the
                // counter starts from zero in SETTLE.
                if (smp_one_hot) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_d = smp_one_hot ? SETTLE : IDLE;
                end else if (cnt_q == CNT_ARM) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                // A change arriving during the capture cycle starts the next
                // dwell straight away; HOLD would otherwise never see it.
                if (changed) begin
                    state_d = smp_one_hot ? SETTLE : IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (changed) begin
                    state_d = smp_one_hot ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture datapath. prev_*_q holds the stable sample throughout CAPTURE,
    // even if the live sample moves on during that cycle.
    // -------------------------------------------------------------------------
    logic [4:0]        dec;
    logic              blank;
    logic [DIGITS-1:0] mask_next;

    assign dec       = hex_decode(prev_seg_q[6:0]);
    assign blank     = (prev_seg_q[6:0] == 7'h00);
    assign mask_next = mask_q | prev_an_q;

    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        bad_d   = 1'b0;
        frame_d = 1'b0;
        if (capture) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (prev_an_q[k]) begin
                    dp_d[k] = prev_seg_q[7];
                    if (dec[4]) begin
                        value_d[4*k +: 4] = dec[3:0];
                        valid_d[k]        = 1'b1;
                    end else begin
                        valid_d[k] = 1'b0;
                        bad_d      = !blank;
                    end
                end
            end
            if (&mask_next) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d = mask_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes the 2-flop synchronizer a
    // real two-stage delay rather than a single wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            an_s1_q    <= '0;
            an_s2_q    <= '0;
            prev_seg_q <= '0;
            prev_an_q  <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            value_q    <= '0;
            dp_q       <= '0;
            valid_q    <= '0;
            mask_q     <= '0;
            bad_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            an_s1_q    <= an_in;
            an_s2_q    <= an_s1_q;
            prev_seg_q <= prev_seg_d;
            prev_an_q  <= prev_an_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            valid_q    <= valid_d;
            mask_q     <= mask_d;
            bad_q      <= bad_d;
            frame_q    <= frame_d;
        end
    end

    assign value_out   = value_q;
    assign dp_out      = dp_q;
    assign digit_valid = valid_q;
    assign bad_pattern = bad_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seven_seg_sniffer.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_sniffer
//
// Directed scenarios for reset, normal capture, short dwells, bad patterns,
// ghosting and reset mid-dwell, followed by a randomized run of display dwells
// compared against a dwell-level reference model.
// -----------------------------------------------------------------------------
module tb_seven_seg_sniffer;

    localparam int DIGITS = 4;
    localparam int S      = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        bad_pattern;
    logic        frame_done;

    seven_seg_sniffer #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (S),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .value_out  (value_out),
        .dp_out     (dp_out),
        .digit_valid(digit_valid),
        .bad_pattern(bad_pattern),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse monitors, sampled away from the active edge
    int bad_seen   = 0;
    int frame_seen = 0;
    always @(negedge clk) begin
        if (bad_pattern === 1'b1) bad_seen++;
        if (frame_done === 1'b1) frame_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Reference model: one display dwell at a time, active-high hex table
    // ---------------------------------------------------------------------
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0] m_value;
    logic [3:0]  m_valid, m_dp, m_mask;
    int          m_bad, m_frame;

    function automatic int ref_lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (hex_tab[i] == p) return i;
        end
        return -1;
    endfunction

    // A dwell of n clocks with one digit selected is captured exactly once
    // when n >= S; anything shorter or not single-digit is ignored.
    task automatic model_dwell(input logic [3:0] an_raw, input logic [7:0] seg_raw, input int n);
        logic [3:0] an_hi;
        logic [7:0] seg_hi;
        int k;
        int d;
        an_hi  = ~an_raw;
        seg_hi = ~seg_raw;
        if ($countones(an_hi) == 1 && n >= S) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (an_hi[i]) k = i;
            m_dp[k] = seg_hi[7];
            d = ref_lookup(seg_hi[6:0]);
            if (d >= 0) begin
                m_value[4*k +: 4] = d[3:0];
                m_valid[k]        = 1'b1;
            end else begin
                m_valid[k] = 1'b0;
                if (seg_hi[6:0] != 7'h00) m_bad++;
            end
            m_mask[k] = 1'b1;
            if (m_mask == 4'hF) begin
                m_frame++;
                m_mask = 4'h0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, f0;
        int n;
        logic [3:0] an_r, prev_an;
        logic [7:0] seg_r, prev_seg;
        int r;

        // ---------------- Test 1: reset with random inputs ----------------
        rst    = 1'b1;
        an_in  = 4'($urandom);
        seg_in = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            an_in  = 4'($urandom);
            seg_in = 8'($urandom);
        end
        check("rst_value", 32'(value_out), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_pulses", 32'(bad_seen + frame_seen), 32'h0);

        // ---------------- Test 2: display 2345 ----------------
        an_in  = 4'b0111;
        seg_in = 8'hA4;
        rst    = 1'b0;
        f0     = frame_seen;
        b0     = bad_seen;
        tick(20);
        an_in = 4'b1011; seg_in = 8'hB0; tick(20);
        an_in = 4'b1101; seg_in = 8'h99; tick(20);
        check("t2_frame_before_d0", 32'(frame_seen - f0), 32'd0);
        an_in = 4'b1110; seg_in = 8'h92; tick(20);
        check("t2_value", 32'(value_out), 32'h2345);
        check("t2_valid", 32'(digit_valid), 32'hF);
        check("t2_dp", 32'(dp_out), 32'h0);
        check("t2_frame", 32'(frame_seen - f0), 32'd1);
        check("t2_bad", 32'(bad_seen - b0), 32'd0);

        // ---------------- Test 3: dwells too short ----------------
        f0 = frame_seen;
        b0 = bad_seen;
        an_in = 4'b1110; seg_in = 8'hC0; tick(5);
        seg_in = 8'hF9; tick(5);
        an_in = 4'b1111; seg_in = 8'hFF; tick(15);
        check("t3_value", 32'(value_out), 32'h2345);
        check("t3_valid", 32'(digit_valid), 32'hF);
        check("t3_pulses", 32'(frame_seen - f0 + bad_seen - b0), 32'd0);

        // ---------------- Test 4: bad pattern on digit1 ----------------
        f0 = frame_seen;
        b0 = bad_seen;
        an_in = 4'b1101; seg_in = 8'hB6; tick(20);
        check("t4_bad", 32'(bad_seen - b0), 32'd1);
        check("t4_valid", 32'(digit_valid), 32'hD);
        check("t4_value", 32'(value_out), 32'h2345);
        check("t4_frame", 32'(frame_seen - f0), 32'd0);

        // ---------------- Test 5: two anodes (ghost) then digit0 ----------------
        b0 = bad_seen;
        an_in = 4'b1100; seg_in = 8'h80; tick(50);
        check("t5_ghost_value", 32'(value_out), 32'h2345);
        check("t5_ghost_dp", 32'(dp_out), 32'h0);
        check("t5_ghost_valid", 32'(digit_valid), 32'hD);
        an_in = 4'b1110; seg_in = 8'h40; tick(20);
        check("t5_value", 32'(value_out), 32'h2340);
        check("t5_dp", 32'(dp_out), 32'h1);
        check("t5_valid", 32'(digit_valid), 32'hD);
        check("t5_bad", 32'(bad_seen - b0), 32'd0);

        // ---------------- Test 6: reset mid-dwell ----------------
        an_in = 4'b1110; seg_in = 8'h92; tick(7);
        rst = 1'b1;
        #1;
        check("t6_rst_value", 32'(value_out), 32'h0);
        check("t6_rst_dp", 32'(dp_out), 32'h0);
        check("t6_rst_valid", 32'(digit_valid), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(S + 2);
        check("t6_early_valid", 32'(digit_valid), 32'h0);
        tick(1);
        check("t6_cap_valid", 32'(digit_valid), 32'h1);
        check("t6_cap_value", 32'(value_out), 32'h0005);
        tick(5);

        // ---------------- Randomized dwells vs model ----------------
        rst = 1'b1;
        an_in  = 4'hF;
        seg_in = 8'hFF;
        tick(2);
        rst = 1'b0;
        tick(5);
        m_value = '0; m_valid = '0; m_dp = '0; m_mask = '0;
        m_bad = 0; m_frame = 0;
        b0 = bad_seen;
        f0 = frame_seen;
        prev_an  = 4'hF;
        prev_seg = 8'hFF;
        for (int i = 0; i < 60; i++) begin
            do begin
                if ($urandom_range(9, 0) < 7) an_r = ~(4'b0001 << $urandom_range(3, 0));
                else                          an_r = 4'($urandom);
                r = int'($urandom_range(9, 0));
                if (r < 5)      seg_r = ~{1'($urandom), hex_tab[$urandom_range(15, 0)]};
                else if (r < 7) seg_r = ~{1'($urandom), 7'h00};
                else            seg_r = 8'($urandom);
            end while ({an_r, seg_r} == {prev_an, prev_seg});
            n = int'($urandom_range(S + 6, S - 3));
            an_in  = an_r;
            seg_in = seg_r;
            tick(4);
            // Previous dwell has committed by now; this one cannot have yet.
            check("rnd_value", 32'(value_out), 32'(m_value));
            check("rnd_valid", 32'(digit_valid), 32'(m_valid));
            check("rnd_dp", 32'(dp_out), 32'(m_dp));
            check("rnd_bad", 32'(bad_seen - b0), 32'(m_bad));
            check("rnd_frame", 32'(frame_seen - f0), 32'(m_frame));
            model_dwell(an_r, seg_r, n);
            tick(n - 4);
            prev_an  = an_r;
            prev_seg = seg_r;
        end
        an_in  = 4'hF;
        seg_in = 8'hFF;
        tick(8);
        check("rnd_final_value", 32'(value_out), 32'(m_value));
        check("rnd_final_valid", 32'(digit_valid), 32'(m_valid));
        check("rnd_final_dp", 32'(dp_out), 32'(m_dp));
        check("rnd_final_bad", 32'(bad_seen - b0), 32'(m_bad));
        check("rnd_final_frame", 32'(frame_seen - f0), 32'(m_frame));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
